mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Parametrised N-channel arbiter that lets several block-level requesters share one backing memory. Typical requesters are the instruction cache and the data cache.
- It is the successor to the current setup, where the instruction cache and data cache each have a private memory. The system harness instantiates one arbiter and one unified block memory instead.
- Requester side and memory side both use the codebase read/write/busywait block handshake.
- Round-robin arbitration serves one transaction at a time.

Parameters:
- NUM_CH, 2, number of requester channels (2..8).
- ADDR_W, 28, block address width.
- BLOCK_W, 128, data block width.
- GW, derived as max(1, clog2(NUM_CH)); width of the grant index.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- ch_read  input  NUM_CH  per-channel read request, held until that channel's busywait is low.
- ch_write  input  NUM_CH  per-channel write request, held the same way.
- ch_address  input  NUM_CH*ADDR_W  flattened addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
- ch_writedata  input  NUM_CH*BLOCK_W  flattened write blocks.
- ch_readdata  output  NUM_CH*BLOCK_W  flattened read blocks, registered per channel.
- ch_busywait  output  NUM_CH  per-channel stall.
- mem_read  output  1  read command to memory.
- mem_write  output  1  write command to memory.
- mem_address  output  ADDR_W  memory address.
- mem_writedata  output  BLOCK_W  memory write block.
- mem_readdata  input  BLOCK_W  memory read block.
- mem_busywait  input  1  memory stall.
- grant_ch  output  GW  index of the channel currently owning memory (debug).
- grant_valid  output  1  high in ISSUE, WAIT and DONE.

Behaviour:
- Reset (RESET low, asynchronous):
  - state=IDLE.
  - mem_read, mem_write, mem_address and mem_writedata are 0.
  - All ch_readdata are 0.
  - grant_ch=0, grant_valid=0.
  - rr_ptr=0, where rr_ptr is the highest-priority channel for the next arbitration.
  - Assertion mid-transaction aborts it; the channel retries after reset.
- Request decoding:
  - req[i] = ch_read[i] | ch_write[i].
  - If read and write are both asserted on one channel, it is treated as a write.
- ch_busywait[i] = req[i] & ~(state==DONE & grant_ch==i). This is combinational: a requesting channel stalls until its own DONE cycle.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any req, pick the first requesting channel scanning upward from rr_ptr modulo NUM_CH. Latch its index, op, address and writedata, then go to ISSUE. If no req, stay in IDLE.
  - ISSUE: drive mem_read or mem_write plus the latched address and data, then go to WAIT unconditionally.
  - WAIT: keep driving the command. On a rising edge where mem_busywait is 0, drop the command and go to DONE; for a read, also capture mem_readdata into ch_readdata[grant_ch].
  - DONE: one cycle with ch_busywait[grant_ch]=0. Set rr_ptr=(grant_ch+1) mod NUM_CH, then go to IDLE.
- Memory contract: memory raises mem_busywait no later than the ISSUE cycle, so it is sampled high on the ISSUE→WAIT edge.
- Latency: with a memory holding busywait for M cycles, a lone request sees ch_busywait low 3+M cycles after request assertion. The low pulse is exactly one cycle.
- Requests change only at DONE: new or changed requests during ISSUE/WAIT are ignored until IDLE, because the command is latched.
- ch_readdata[i] holds its value until the next completed read on channel i; writes never modify it.
- Non-granted channels keep ch_busywait high for as long as they request.
- Wrap-around: rr_ptr after serving channel NUM_CH-1 is 0.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: rr_ptr is ignored and arbitration always scans from channel 0, so channel 0 (instruction fetch) always wins.
- Undefined: round-robin as above.
- Handshake, FSM and latencies are identical in both builds.

Test Plan:
- Reset: hold RESET low with random inputs → all outputs 0, state IDLE; release → no memory command without a request.
- Single read: ch0 reads address 0x0000010, memory returns 0xDEADBEEF_00000001_CAFEF00D_12345678 after 5 busy cycles → ch_readdata[0] equals that block; ch_busywait[0] is low for exactly one cycle, 8 cycles after request; mem_read high for exactly 6 cycles.
- Contention: ch0 and ch1 request continuously from reset → grants alternate 0,1,0,1. With ARB_FIXED_PRIO_EN and ch0 re-requesting immediately, grants are 0,0,0.
- Write: ch1 writes 0xA5 (repeated across the block) to 0x0000020 → mem_write is asserted with that address/data; ch_readdata[1] is unchanged. A following ch1 read of 0x0000020 returns the written block.
- Read+write same channel: both asserted → only mem_write is issued.
- Reset mid-WAIT: drop RESET low during WAIT → mem_read is low immediately (asynchronous); after release the pending channel is re-served from IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel round-robin arbiter sharing one block memory over the read/write/busywait handshake.
// Define ARB_FIXED_PRIO_EN to make arbitration always scan from channel 0 (fixed priority).
module mem_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128,
    parameter int GW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_CH-1:0]          ch_read,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
    input  logic [NUM_CH*BLOCK_W-1:0]  ch_writedata,
    output logic [NUM_CH*BLOCK_W-1:0]  ch_readdata,
    output logic [NUM_CH-1:0]          ch_busywait,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [BLOCK_W-1:0]         mem_writedata,
    input  logic [BLOCK_W-1:0]         mem_readdata,
    input  logic                       mem_busywait,
    output logic [GW-1:0]              grant_ch,
    output logic                       grant_valid
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, state_nx;
    logic [NUM_CH-1:0] req;
    logic [GW-1:0]     rr_ptr, pick, idx;
    logic              pick_valid, op_wr, cmd;

    assign req = ch_read | ch_write;

    // Downward scan with overwrite leaves the channel closest to rr_ptr as the winner
    always_comb begin
        pick = '0;
        pick_valid = 1'b0;
        idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = GW'((int'(rr_ptr) + k) % NUM_CH);
            if (req[idx]) begin
                pick = idx;
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE)  ? (pick_valid ? ISSUE : IDLE) :
                   (state == ISSUE) ? WAIT :
                   (state == WAIT)  ? (mem_busywait ? WAIT : DONE) : IDLE;
    end

    always_comb begin
        cmd = (state == ISSUE) || (state == WAIT);
        mem_read = cmd & ~op_wr;
        mem_write = cmd & op_wr;
        grant_valid = state != IDLE;
        ch_busywait = '0;
        for (int i = 0; i < NUM_CH; i++)
            ch_busywait[i] = req[i] & ~(state == DONE && grant_ch == GW'(i));
    end

    // Command is latched in IDLE so requests changing mid-transaction are ignored
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            grant_ch <= '0;
            op_wr <= 1'b0;
            mem_address <= '0;
            mem_writedata <= '0;
            rr_ptr <= '0;
            ch_readdata <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                grant_ch <= pick;
                op_wr <= ch_write[pick];
                mem_address <= ch_address[pick*ADDR_W +: ADDR_W];
                mem_writedata <= ch_writedata[pick*BLOCK_W +: BLOCK_W];
            end
            if (state == WAIT && !mem_busywait && !op_wr)
                ch_readdata[grant_ch*BLOCK_W +: BLOCK_W] <= mem_readdata;
            if (state == DONE)
`ifdef ARB_FIXED_PRIO_EN
                rr_ptr <= '0;
`else
                rr_ptr <= (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural block memory model.
module tb_mem_arbiter;
    localparam int NUM_CH = 2;
    localparam int AW = 28;
    localparam int BW = 128;
    localparam int GW = 1;
    localparam int AFW = NUM_CH * AW;
    localparam int DFW = NUM_CH * BW;

    typedef struct {
        int ch;
        bit wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic [NUM_CH-1:0] ch_read = '0, ch_write = '0;
    logic [AFW-1:0] ch_address = '0;
    logic [DFW-1:0] ch_writedata = '0;
    logic [DFW-1:0] ch_readdata;
    logic [NUM_CH-1:0] ch_busywait;
    logic mem_read, mem_write, mem_busywait;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_writedata, mem_readdata;
    logic [GW-1:0] grant_ch;
    logic grant_valid;

    int checks = 0, failures = 0, done_cnt = 0;
    int mem_lat = 1, busy_cnt = 0;
    int lat, rd_hi, k;
    bit loaded = 1'b0;
    logic last_wr = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [BW-1:0] last_wdata = '0;
    logic [BW-1:0] mem_model [256];
    logic [BW-1:0] ref_mem [256];
    logic [BW-1:0] rd_exp [NUM_CH];
    exp_t sb[$];

    always #5 CLK = ~CLK;

    mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(AW), .BLOCK_W(BW)) dut (
        .CLK(CLK), .RESET(RESET),
        .ch_read(ch_read), .ch_write(ch_write),
        .ch_address(ch_address), .ch_writedata(ch_writedata),
        .ch_readdata(ch_readdata), .ch_busywait(ch_busywait),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .grant_ch(grant_ch), .grant_valid(grant_valid)
    );

    function automatic logic [BW-1:0] pat(input logic [7:0] a);
        return (a == 8'h10) ? 128'hDEADBEEF_00000001_CAFEF00D_12345678 :
               {a, 24'hC0FFEE, a, 24'hBEEF00, a, 24'h123456, a, 24'hABCDEF};
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory stays busy for mem_lat cycles of an active command, then completes it
    assign mem_busywait = (mem_read | mem_write) && (busy_cnt < mem_lat);
    assign mem_readdata = mem_model[mem_address[7:0]];

    always @(posedge CLK) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= pat(8'(i));
            loaded <= 1'b1;
        end else if (mem_read | mem_write) begin
            if (!mem_busywait) begin
                busy_cnt <= 0;
                last_wr <= mem_write;
                last_addr <= mem_address;
                last_wdata <= mem_writedata;
                if (mem_write) mem_model[mem_address[7:0]] <= mem_writedata;
            end else busy_cnt <= busy_cnt + 1;
        end else busy_cnt <= 0;
    end

    always @(negedge CLK) begin
        if (!RESET) begin
            foreach (rd_exp[i]) rd_exp[i] = '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((ch_read[i] | ch_write[i]) && !ch_busywait[i]) begin
                    exp_t e;
                    check("sb_avail", BW'(sb.size() != 0), BW'(1));
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("grant", BW'(i), BW'(e.ch));
                        check("grant_ch", BW'(grant_ch), BW'(e.ch));
                        check("op_wr", BW'(last_wr), BW'(e.wr));
                        check("mem_addr", BW'(last_addr), BW'(e.addr));
                        if (e.wr) check("mem_wdata", last_wdata, e.data);
                        else rd_exp[i] = e.data;
                        check("rdata", ch_readdata[i*BW +: BW], rd_exp[i]);
                    end
                    done_cnt++;
                end
            end
        end
    end

    task automatic drive(input int c, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] d);
        exp_t e;
        e.ch = c;
        e.wr = wr;
        e.addr = a;
        e.data = wr ? d : ref_mem[a[7:0]];
        if (wr) ref_mem[a[7:0]] = d;
        sb.push_back(e);
        ch_read[c] = rd;
        ch_write[c] = wr;
        ch_address[c*AW +: AW] = a;
        ch_writedata[c*BW +: BW] = d;
    endtask

    task automatic wait_done(input int n, output int l, output int r);
        l = 1;
        r = 0;
        while (done_cnt < n && l < 200) begin
            @(negedge CLK);
            #1;
            l++;
            r += int'(mem_read);
        end
        check("done_seen", BW'(done_cnt >= n), BW'(1));
    endtask

    task automatic finish_txn(input int c);
        @(negedge CLK);
        #1;
        check("pulse_end", BW'(ch_busywait[c]), BW'(1));
        ch_read[c] = 1'b0;
        ch_write[c] = 1'b0;
    endtask

    task automatic txn(input int c, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] d,
                       output int l, output int r);
        @(negedge CLK);
        #1;
        drive(c, rd, wr, a, d);
        wait_done(done_cnt + 1, l, r);
        finish_txn(c);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1;
        RESET = 1'b0;
        ch_read = '0;
        ch_write = '0;
        sb.delete();
        repeat (2) @(negedge CLK);
        #1 RESET = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
        repeat (3) begin
            ch_read = NUM_CH'($urandom);
            ch_write = NUM_CH'($urandom);
            ch_address = AFW'({$urandom, $urandom});
            ch_writedata = {8{$urandom}};
            @(negedge CLK);
        end
        check("rst_mem_read", BW'(mem_read), BW'(0));
        check("rst_mem_write", BW'(mem_write), BW'(0));
        check("rst_mem_addr", BW'(mem_address), BW'(0));
        check("rst_mem_wdata", mem_writedata, BW'(0));
        check("rst_rdata", BW'(|ch_readdata), BW'(0));
        check("rst_grant_ch", BW'(grant_ch), BW'(0));
        check("rst_grant_valid", BW'(grant_valid), BW'(0));
        ch_read = '0;
        ch_write = '0;
        #1 RESET = 1'b1;
        k = 0;
        repeat (5) begin
            @(negedge CLK);
            k += int'(mem_read | mem_write | grant_valid);
        end
        check("idle_nocmd", BW'(k), BW'(0));

        mem_lat = 5;
        txn(0, 1'b1, 1'b0, 28'h10, '0, lat, rd_hi);
        check("rd_latency", BW'(lat), BW'(3 + 5));
        check("rd_cmd_cycles", BW'(rd_hi), BW'(6));

        mem_lat = 2;
        txn(1, 1'b0, 1'b1, 28'h20, {16{8'hA5}}, lat, rd_hi);
        check("wr_no_read", BW'(rd_hi), BW'(0));
        txn(1, 1'b1, 1'b0, 28'h20, '0, lat, rd_hi);
        check("rd2_latency", BW'(lat), BW'(3 + 2));
        txn(0, 1'b1, 1'b1, 28'h40, {4{32'h5A5A1234}}, lat, rd_hi);
        check("rw_no_read", BW'(rd_hi), BW'(0));

        do_reset();
        mem_lat = 1;
        @(negedge CLK);
        #1;
`ifdef ARB_FIXED_PRIO_EN
        repeat (4) drive(0, 1'b1, 1'b0, 28'h10, '0);
        ch_read[1] = 1'b1;
        ch_address[AW +: AW] = 28'h30;
`else
        repeat (2) begin
            drive(0, 1'b1, 1'b0, 28'h10, '0);
            drive(1, 1'b1, 1'b0, 28'h30, '0);
        end
`endif
        wait_done(done_cnt + 4, lat, rd_hi);
        ch_read = '0;
        ch_write = '0;
        @(negedge CLK);
        #1;
        check("contend_drained", BW'(sb.size()), BW'(0));

        mem_lat = 10;
        drive(0, 1'b1, 1'b0, 28'h30, '0);
        k = 0;
        for (int t = 0; t < 20 && k < 2; t++) begin
            @(negedge CLK);
            #1;
            if (mem_read) k++;
        end
        check("wait_reached", BW'(k), BW'(2));
        RESET = 1'b0;
        #1;
        check("arst_mem_read", BW'(mem_read), BW'(0));
        check("arst_grant_valid", BW'(grant_valid), BW'(0));
        mem_lat = 3;
        repeat (2) @(negedge CLK);
        #1 RESET = 1'b1;
        wait_done(done_cnt + 1, lat, rd_hi);
        finish_txn(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
